// File: rtl/intersection_phase_scheduler.sv
// Two-street intersection phase scheduler with pedestrian service and tick-based timing.
// Optional EMERGENCY_PREEMPT_EN adds an emerg input that preempts side/ped phases and freezes main green.
module intersection_phase_scheduler #(
  parameter int MAIN_MIN_GREEN = 10,
  parameter int YELLOW_TIME    = 3,
  parameter int ALL_RED_TIME   = 2,
  parameter int SIDE_GREEN     = 10,
  parameter int WALK_TIME      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic       emerg,
`endif
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam logic [2:0] INIT     = 3'd0;
  localparam logic [2:0] MAIN_G   = 3'd1;
  localparam logic [2:0] MAIN_Y   = 3'd2;
  localparam logic [2:0] ALL_R1   = 3'd3;
  localparam logic [2:0] SIDE_G   = 3'd4;
  localparam logic [2:0] SIDE_Y   = 3'd5;
  localparam logic [2:0] PED_WALK = 3'd6;
  localparam logic [2:0] ALL_R2   = 3'd7;

  localparam logic [3:0] MIN_G_T  = 4'(MAIN_MIN_GREEN);
  localparam logic [3:0] YEL_T    = 4'(YELLOW_TIME);
  localparam logic [3:0] RED_T    = 4'(ALL_RED_TIME);
  localparam logic [3:0] SIDE_G_T = 4'(SIDE_GREEN);
  localparam logic [3:0] WALK_T   = 4'(WALK_TIME);

  // grant / last_served encoding: 0 = side street, 1 = pedestrian
  localparam logic GRANT_SIDE = 1'b0;
  localparam logic GRANT_PED  = 1'b1;

  logic [2:0] state, state_nx, dest;
  logic [3:0] cnt, cnt_nx, dur;
  logic       ped_pend, ped_pend_nx;
  logic       grant, grant_nx;
  logic       last_served, last_nx;
  logic       emerg_i;
  logic       entering_walk;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_i = emerg;
`else
  assign emerg_i = 1'b0;
`endif

  function automatic logic [3:0] sat_inc(input logic [3:0] c, input logic [3:0] lim);
    return (c >= lim) ? lim : c + 4'd1;
  endfunction

  always_comb begin
    dur  = RED_T;
    dest = MAIN_G;
    case (state)
      INIT:     begin dur = RED_T;    dest = MAIN_G; end
      MAIN_G:   begin dur = MIN_G_T;  dest = MAIN_Y; end
      MAIN_Y:   begin dur = YEL_T;    dest = ALL_R1; end
      ALL_R1:   begin dur = RED_T;    dest = (grant == GRANT_PED) ? PED_WALK : SIDE_G; end
      SIDE_G:   begin dur = SIDE_G_T; dest = SIDE_Y; end
      SIDE_Y:   begin dur = YEL_T;    dest = ALL_R2; end
      PED_WALK: begin dur = WALK_T;   dest = ALL_R2; end
      default:  begin dur = RED_T;    dest = MAIN_G; end
    endcase
  end

  // Main green saturates and waits for demand; every other state is a fixed dwell.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    grant_nx = grant;
    last_nx  = last_served;
    if (state == MAIN_G) begin
      if (tick && !emerg_i) begin
        cnt_nx = sat_inc(cnt, dur);
        if (cnt_nx == dur && (side_req || ped_pend)) begin
          state_nx = dest;
          grant_nx = (side_req && ped_pend) ? ~last_served : ped_pend;
        end
      end
    end else if (emerg_i && (state == SIDE_G || state == PED_WALK)) begin
      state_nx = dest;
    end else if (tick) begin
      cnt_nx = cnt + 4'd1;
      if (cnt_nx == dur) state_nx = dest;
    end
    if (state == ALL_R1 && state_nx != state) last_nx = grant;
    if (state_nx != state) cnt_nx = '0;
  end

  assign entering_walk = (state_nx == PED_WALK) && (state != PED_WALK);
  assign ped_pend_nx   = entering_walk ? 1'b0 : (ped_pend | ped_req);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= INIT;
      cnt         <= '0;
      ped_pend    <= 1'b0;
      grant       <= GRANT_SIDE;
      last_served <= GRANT_PED;
      ped_ack     <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ped_pend    <= ped_pend_nx;
      grant       <= grant_nx;
      last_served <= last_nx;
      ped_ack     <= entering_walk;
    end
  end

  always_comb begin
    main_lights = 3'b100;
    side_lights = 3'b100;
    case (state)
      MAIN_G:  main_lights = 3'b001;
      MAIN_Y:  main_lights = 3'b010;
      SIDE_G:  side_lights = 3'b001;
      SIDE_Y:  side_lights = 3'b010;
      default: ;
    endcase
  end

  assign walk  = (state == PED_WALK);
  assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with default parameters.
// Covers idle, side service, pedestrian service, alternation, and reset mid-walk.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
`ifdef EMERGENCY_PREEMPT_EN
  logic       emerg = 1'b0;
`endif
  logic [2:0] main_lights, side_lights, phase;
  logic       walk, ped_ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .side_req    (side_req),
    .ped_req     (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .emerg       (emerg),
`endif
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk        (walk),
    .ped_ack     (ped_ack),
    .phase       (phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic pulse_ped();
    @(negedge clk); ped_req = 1'b1;
    @(negedge clk); ped_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_ticks(input int n, input logic [2:0] stay, input logic [2:0] after,
                           input string tag);
    for (int i = 1; i <= n; i++) begin
      do_tick();
      chk($sformatf("%s_t%0d", tag, i), 32'(phase), (i == n) ? 32'(after) : 32'(stay));
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_lights", 32'({main_lights, side_lights}), 32'b100_100);
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_ack", 32'(ped_ack), 32'd0);
    reset = 1'b1;

    // idle: 20 ticks, INIT for 2 then MAIN_G held
    run_ticks(2, 3'd0, 3'd1, "idle_init");
    chk("idle_lights", 32'({main_lights, side_lights}), 32'b001_100);
    run_ticks(18, 3'd1, 3'd1, "idle_hold");

    // side_req that drops before a tick is not pending
    @(negedge clk); side_req = 1'b1;
    @(negedge clk); side_req = 1'b0;
    run_ticks(1, 3'd1, 3'd1, "side_cancel");

    // side service from reset, side_req held from tick 3
    do_reset();
    run_ticks(2, 3'd0, 3'd1, "side_init");
    side_req = 1'b1;
    run_ticks(10, 3'd1, 3'd2, "side_maing");
    chk("side_my_lights", 32'({main_lights, side_lights}), 32'b010_100);
    run_ticks(3, 3'd2, 3'd3, "side_mainy");
    chk("side_ar1_lights", 32'({main_lights, side_lights}), 32'b100_100);
    run_ticks(2, 3'd3, 3'd4, "side_allr1");
    chk("side_sg_lights", 32'({main_lights, side_lights}), 32'b100_001);
    chk("side_sg_ack", 32'(ped_ack), 32'd0);
    side_req = 1'b0;
    run_ticks(10, 3'd4, 3'd5, "side_sideg");
    chk("side_sy_lights", 32'({main_lights, side_lights}), 32'b100_010);
    run_ticks(3, 3'd5, 3'd7, "side_sidey");
    run_ticks(2, 3'd7, 3'd1, "side_allr2");

    // one-clk pedestrian pulse during MAIN_G
    pulse_ped();
    run_ticks(10, 3'd1, 3'd2, "ped_maing");
    run_ticks(3, 3'd2, 3'd3, "ped_mainy");
    run_ticks(2, 3'd3, 3'd6, "ped_allr1");
    chk("ped_ack_hi", 32'(ped_ack), 32'd1);
    chk("ped_walk_hi", 32'(walk), 32'd1);
    chk("ped_lights", 32'({main_lights, side_lights}), 32'b100_100);
    @(negedge clk);
    chk("ped_ack_lo", 32'(ped_ack), 32'd0);
    run_ticks(7, 3'd6, 3'd6, "ped_walk");
    chk("ped_walk_mid", 32'(walk), 32'd1);
    run_ticks(1, 3'd6, 3'd7, "ped_walk_end");
    chk("ped_walk_lo", 32'(walk), 32'd0);
    run_ticks(2, 3'd7, 3'd1, "ped_allr2");
    run_ticks(12, 3'd1, 3'd1, "ped_served");

    // both pending after reset: side first, then ped, ped repeated in walk
    do_reset();
    side_req = 1'b1;
    pulse_ped();
    run_ticks(2, 3'd0, 3'd1, "both_init");
    run_ticks(10, 3'd1, 3'd2, "both_maing1");
    run_ticks(3, 3'd2, 3'd3, "both_mainy1");
    run_ticks(2, 3'd3, 3'd4, "both_allr1_1");
    side_req = 1'b0;
    run_ticks(10, 3'd4, 3'd5, "both_sideg");
    run_ticks(3, 3'd5, 3'd7, "both_sidey");
    run_ticks(2, 3'd7, 3'd1, "both_allr2_1");
    run_ticks(10, 3'd1, 3'd2, "both_maing2");
    run_ticks(3, 3'd2, 3'd3, "both_mainy2");
    run_ticks(2, 3'd3, 3'd6, "both_allr1_2");
    chk("both_ack", 32'(ped_ack), 32'd1);
    pulse_ped();
    run_ticks(8, 3'd6, 3'd7, "both_walk");
    run_ticks(2, 3'd7, 3'd1, "both_allr2_2");
    run_ticks(10, 3'd1, 3'd2, "again_maing");
    run_ticks(3, 3'd2, 3'd3, "again_mainy");
    run_ticks(2, 3'd3, 3'd6, "again_allr1");

    // reset on the 4th tick of PED_WALK
    run_ticks(3, 3'd6, 3'd6, "rw_walk");
    @(negedge clk); tick = 1'b1; reset = 1'b0;
    @(negedge clk); tick = 1'b0;
    chk("rw_phase", 32'(phase), 32'd0);
    chk("rw_walk", 32'(walk), 32'd0);
    chk("rw_ack", 32'(ped_ack), 32'd0);
    chk("rw_lights", 32'({main_lights, side_lights}), 32'b100_100);
    reset = 1'b1;
    run_ticks(2, 3'd0, 3'd1, "rw_init");
    run_ticks(12, 3'd1, 3'd1, "rw_nopend");

`ifdef EMERGENCY_PREEMPT_EN
    side_req = 1'b1;
    run_ticks(1, 3'd1, 3'd2, "em_exit");
    run_ticks(3, 3'd2, 3'd3, "em_mainy");
    run_ticks(2, 3'd3, 3'd4, "em_allr1");
    side_req = 1'b0;
    run_ticks(2, 3'd4, 3'd4, "em_sideg");
    @(negedge clk); emerg = 1'b1;
    @(negedge clk); emerg = 1'b0;
    chk("em_preempt", 32'(phase), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
